// File: rtl/cla_adder_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor. The carry chain is cut into
// STAGES slices, each a chain of 4-bit lookahead groups, under a valid/ready handshake.
module cla_adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int GROUP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int SLICE = WIDTH / STAGES;
   localparam int NGRP  = SLICE / GROUP;

   // One slice: group carries by lookahead from group G/P, bit carries by lookahead inside a group.
   function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             c_in);
      logic [SLICE-1:0] s;
      logic [NGRP:0]    gc;
      logic [3:0]       gl;
      logic [3:0]       pl;
      logic [3:0]       bc;
      s     = '0;
      gc    = '0;
      gc[0] = c_in;
      for (int i = 0; i < NGRP; i++) begin
         gl    = x[GROUP*i +: GROUP] & y[GROUP*i +: GROUP];
         pl    = x[GROUP*i +: GROUP] | y[GROUP*i +: GROUP];
         bc[0] = gc[i];
         bc[1] = gl[0] | (pl[0] & gc[i]);
         bc[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & gc[i]);
         bc[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
               | (pl[2] & pl[1] & pl[0] & gc[i]);
         gc[i+1] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                 | (pl[3] & pl[2] & pl[1] & gl[0]) | ((&pl) & gc[i]);
         s[GROUP*i +: GROUP] = x[GROUP*i +: GROUP] ^ y[GROUP*i +: GROUP] ^ bc;
      end
      return {gc[NGRP], s};
   endfunction

   logic                          adv;
   logic                          accept;
   logic [WIDTH-1:0]              b_eff;
   logic                          c0;

   logic [STAGES-1:0]             vld_q;
   logic [STAGES-1:0]             cy_q;
   logic [STAGES-1:0][WIDTH-1:0]  sum_q;
   logic [STAGES-1:0][WIDTH-1:0]  a_q;
   logic [STAGES-1:0][WIDTH-1:0]  b_q;
   logic                          ovf_q;
   logic                          zero_q;

   logic [STAGES-1:0][WIDTH-1:0]  st_a;
   logic [STAGES-1:0][WIDTH-1:0]  st_b;
   logic [STAGES-1:0][WIDTH-1:0]  st_sum;
   logic [STAGES-1:0]             st_c;
   logic [STAGES-1:0]             st_v;
   logic [STAGES-1:0][SLICE:0]    slice_res;
   logic [STAGES-1:0][WIDTH-1:0]  sum_d;
   logic [STAGES-1:0]             cy_d;
   logic                          ovf_d;
   logic                          zero_d;
   logic                          unused_bits;

   assign out_valid = vld_q[STAGES-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv && !flush;
   assign accept    = in_valid && in_ready;
   assign b_eff     = sub ? ~b : b;
   assign c0        = sub ? 1'b1 : cin;

   // Stage k sees its predecessor's registers (stage 0 sees the ports) and adds slice k.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << (k*SLICE);
      if (k == 0) begin : g_first
         assign st_a[k]   = a;
         assign st_b[k]   = b_eff;
         assign st_sum[k] = '0;
         assign st_c[k]   = c0;
         assign st_v[k]   = accept;
      end else begin : g_next
         assign st_a[k]   = a_q[k-1];
         assign st_b[k]   = b_q[k-1];
         assign st_sum[k] = sum_q[k-1];
         assign st_c[k]   = cy_q[k-1];
         assign st_v[k]   = vld_q[k-1];
      end
      assign slice_res[k] = cla_slice(st_a[k][k*SLICE +: SLICE], st_b[k][k*SLICE +: SLICE], st_c[k]);
      assign sum_d[k]     = (st_sum[k] & ~MASK) | (WIDTH'(slice_res[k][SLICE-1:0]) << (k*SLICE));
      assign cy_d[k]      = slice_res[k][SLICE];
   end

   assign ovf_d  = (st_a[STAGES-1][WIDTH-1] == st_b[STAGES-1][WIDTH-1])
                && (sum_d[STAGES-1][WIDTH-1] != st_a[STAGES-1][WIDTH-1]);
   assign zero_d = ~|sum_d[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: data registers are reset too, so r and the flags read 0 rather than X after reset.
         vld_q  <= '0;
         cy_q   <= '0;
         sum_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         if (flush) begin
            vld_q <= '0;
         end else if (adv) begin
            vld_q <= st_v;
         end
         // Data moves only with a valid token, so outputs keep the last result across bubbles.
         if (adv && !flush) begin
            for (int k = 0; k < STAGES; k++) begin
               if (st_v[k]) begin
                  sum_q[k] <= sum_d[k];
                  a_q[k]   <= st_a[k];
                  b_q[k]   <= st_b[k];
                  cy_q[k]  <= cy_d[k];
               end
            end
            if (st_v[STAGES-1]) begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

   assign r        = sum_q[STAGES-1];
   assign carry    = cy_q[STAGES-1];
   assign overflow = ovf_q;
   assign zero     = zero_q;

   // Already-consumed operand bits and the last stage's operand copies feed nothing.
   assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], st_a, st_b};

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed scenarios on a STAGES=2 unit plus a randomised
// scoreboard run against STAGES=1,2,4 units sharing the same operand stream.
module tb_cla_adder_pipe;

   localparam int W = 32;
   localparam int N = 3;
   localparam int M = 1;

   logic         clk       = 1'b0;
   logic         rst       = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic         flush     = 1'b0;
   logic         sub       = 1'b0;
   logic         cin       = 1'b0;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;

   logic         in_ready_w  [N];
   logic         out_valid_w [N];
   logic         carry_w     [N];
   logic         ovf_w       [N];
   logic         zero_w      [N];
   logic [W-1:0] r_w         [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      cla_adder_pipe #(.WIDTH(W), .STAGES(1 << g), .GROUP(4)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[g]),
         .a         (a),
         .b         (b),
         .sub       (sub),
         .cin       (cin),
         .flush     (flush),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .r         (r_w[g]),
         .carry     (carry_w[g]),
         .overflow  (ovf_w[g]),
         .zero      (zero_w[g])
      );
   end

   // Reference: plain integer arithmetic, packed as {overflow, carry, zero, r}.
   function automatic logic [W+2:0] model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                          input logic ts, input logic tc);
      longint          sres;
      longint unsigned us;
      logic [W-1:0]    rr;
      logic            cy;
      if (ts) begin
         rr   = ta - tbv;
         cy   = (ta >= tbv);
         sres = longint'($signed(ta)) - longint'($signed(tbv));
      end else begin
         us   = longint'(ta) + longint'(tbv) + longint'(tc);
         rr   = us[W-1:0];
         cy   = us[W];
         sres = longint'($signed(ta)) + longint'($signed(tbv)) + longint'(tc);
      end
      return {(sres != longint'($signed(rr))), cy, (rr == '0), rr};
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic ts, input logic tc);
      @(posedge clk); #1;
      a = ta; b = tbv; sub = ts; cin = tc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         total++;
         if ({out_valid_w[i], carry_w[i], ovf_w[i], zero_w[i], r_w[i]} !== '0) begin
            bad++;
            $display("FAIL reset_state[%0d]: got v=%b c=%b o=%b z=%b r=%h exp all 0", i,
                     out_valid_w[i], carry_w[i], ovf_w[i], zero_w[i], r_w[i]);
         end
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready_w[M] !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready_w[M]);
      end
   endtask

   task automatic test_add_wrap;
      out_ready = 1'b1;
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (out_valid_w[M] !== 1'b0) begin
         bad++; $display("FAIL add_early_valid: got %b exp 0", out_valid_w[M]);
      end
      total++;
      if ({out_valid_w[0], r_w[0]} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL stages1_latency: got v=%b r=%h exp v=1 r=0", out_valid_w[0], r_w[0]);
      end
      @(negedge clk);
      total++;
      if ({out_valid_w[M], carry_w[M], ovf_w[M], zero_w[M]} !== 4'b1101) begin
         bad++; $display("FAIL add_wrap_flags: got v/c/o/z=%b%b%b%b exp 1101",
                         out_valid_w[M], carry_w[M], ovf_w[M], zero_w[M]);
      end
      total++;
      if (r_w[M] !== 32'h0) begin
         bad++; $display("FAIL add_wrap_r: got %h exp 00000000", r_w[M]);
      end
      @(negedge clk);
      total++;
      if (out_valid_w[2] !== 1'b0) begin
         bad++; $display("FAIL stages4_early_valid: got %b exp 0", out_valid_w[2]);
      end
      @(negedge clk);
      total++;
      if ({out_valid_w[2], carry_w[2], r_w[2]} !== {2'b11, 32'h0}) begin
         bad++; $display("FAIL stages4_latency: got v=%b c=%b r=%h exp v=1 c=1 r=0",
                         out_valid_w[2], carry_w[2], r_w[2]);
      end
   endtask

   task automatic test_sub;
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]} !== {1'b1, 32'h7FFF_FFFF, 3'b110}) begin
         bad++; $display("FAIL sub_overflow: got v=%b r=%h c/o/z=%b%b%b exp v=1 r=7fffffff c/o/z=110",
                         out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]);
      end
      issue(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]} !== {1'b1, 32'hFFFF_FFFE, 3'b000}) begin
         bad++; $display("FAIL sub_borrow: got v=%b r=%h c/o/z=%b%b%b exp v=1 r=fffffffe c/o/z=000",
                         out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]);
      end
   endtask

   task automatic test_cross_slice;
      issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M], carry_w[M], zero_w[M]} !== {1'b1, 32'h0001_0001, 2'b00}) begin
         bad++; $display("FAIL cross_slice: got v=%b r=%h c=%b z=%b exp v=1 r=00010001 c=0 z=0",
                         out_valid_w[M], r_w[M], carry_w[M], zero_w[M]);
      end
   endtask

   task automatic test_back_to_back;
      int           i;
      int           cyc;
      int           got_n;
      int           extra;
      logic         acc;
      logic [W-1:0] got [8];
      @(posedge clk); #1;
      out_ready = 1'b0; a = 32'd1; b = 32'd1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      i = 1; cyc = 0;
      while (cyc < 10) begin
         @(negedge clk);
         if (!in_ready_w[M]) break;
         @(posedge clk); #1;
         i++; a = W'(i); b = W'(i); cyc++;
      end
      total++;
      if ({in_ready_w[M], out_valid_w[M], r_w[M]} !== {2'b01, 32'd2}) begin
         bad++; $display("FAIL stall_state: got rdy=%b v=%b r=%h exp rdy=0 v=1 r=2",
                         in_ready_w[M], out_valid_w[M], r_w[M]);
      end
      total++;
      if (i - 1 != 2) begin
         bad++; $display("FAIL stall_depth: got %0d accepted exp 2", i - 1);
      end
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         total++;
         if ({in_ready_w[M], out_valid_w[M], r_w[M]} !== {2'b01, 32'd2}) begin
            bad++; $display("FAIL stall_hold: got rdy=%b v=%b r=%h exp rdy=0 v=1 r=2",
                            in_ready_w[M], out_valid_w[M], r_w[M]);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      got_n = 0; cyc = 0;
      while (got_n < 4 && cyc < 20) begin
         @(negedge clk);
         acc = in_valid && in_ready_w[M];
         if (out_valid_w[M]) begin
            got[got_n] = r_w[M];
            got_n++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (i < 4) begin
               i++; a = W'(i); b = W'(i);
            end else begin
               in_valid = 1'b0;
            end
         end
         cyc++;
      end
      total++;
      if (got_n != 4 || cyc != 4) begin
         bad++; $display("FAIL drain_count: got %0d results in %0d cycles exp 4 in 4", got_n, cyc);
      end
      for (int k = 0; k < got_n; k++) begin
         total++;
         if (got[k] !== W'(2 * (k + 1))) begin
            bad++; $display("FAIL drain_order[%0d]: got %h exp %h", k, got[k], W'(2 * (k + 1)));
         end
      end
      in_valid = 1'b0;
      extra = 0;
      for (int h = 0; h < 4; h++) begin
         @(negedge clk);
         if (out_valid_w[M]) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++; $display("FAIL drain_duplicate: got %0d extra results exp 0", extra);
      end
   endtask

   task automatic test_flush;
      int seen;
      @(posedge clk); #1;
      out_ready = 1'b1; sub = 1'b0; cin = 1'b0; a = 32'd10; b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd20; b = 32'd2;
      @(posedge clk); #1;
      flush = 1'b1; a = 32'd30; b = 32'd3;
      @(negedge clk);
      total++;
      if ({in_ready_w[M], out_valid_w[M]} !== 2'b01) begin
         bad++; $display("FAIL flush_cycle: got rdy=%b v=%b exp rdy=0 v=1", in_ready_w[M], out_valid_w[M]);
      end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M]} !== {1'b0, 32'd11}) begin
         bad++; $display("FAIL flush_after: got v=%b r=%h exp v=0 r=0000000b", out_valid_w[M], r_w[M]);
      end
      seen = 0;
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         if (out_valid_w[M]) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL flush_leak: got %0d results exp 0", seen);
      end
      issue(32'd5, 32'd6, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (out_valid_w[M] !== 1'b0) begin
         bad++; $display("FAIL flush_next_early: got %b exp 0", out_valid_w[M]);
      end
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M]} !== {1'b1, 32'd11}) begin
         bad++; $display("FAIL flush_next: got v=%b r=%h exp v=1 r=0000000b", out_valid_w[M], r_w[M]);
      end
   endtask

   task automatic test_async_reset;
      @(posedge clk); #1 out_ready = 1'b0;
      issue(32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]} !== {1'b1, 32'h4000_0000, 3'b110}) begin
         bad++; $display("FAIL pre_reset: got v=%b r=%h c/o/z=%b%b%b exp v=1 r=40000000 c/o/z=110",
                         out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]} !== '0) begin
         bad++; $display("FAIL async_reset: got v=%b r=%h c/o/z=%b%b%b exp all 0",
                         out_valid_w[M], r_w[M], carry_w[M], ovf_w[M], zero_w[M]);
      end
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_random;
      int           wr [N];
      int           rd [N];
      logic [W+2:0] exp_mem [N][16];
      logic [W+2:0] got;
      localparam int CYC = 12000;
      for (int i = 0; i < N; i++) begin
         wr[i] = 0; rd[i] = 0;
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < CYC + 12; c++) begin
         @(posedge clk); #1;
         if (c < CYC) begin
            in_valid  = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(7) != 0);
            a = pick(); b = pick();
            sub = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (out_valid_w[i] && out_ready) begin
               total++;
               got = {ovf_w[i], carry_w[i], zero_w[i], r_w[i]};
               if (rd[i] == wr[i]) begin
                  bad++; $display("FAIL rand_unexpected[%0d]: got %h exp no result", i, got);
               end else begin
                  if (got !== exp_mem[i][rd[i] % 16]) begin
                     bad++; $display("FAIL rand_result[%0d] #%0d: got o/c/z/r=%h exp %h",
                                     i, rd[i], got, exp_mem[i][rd[i] % 16]);
                  end
                  rd[i]++;
               end
            end
            if (in_valid && in_ready_w[i]) begin
               exp_mem[i][wr[i] % 16] = model(a, b, sub, cin);
               wr[i]++;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (rd[i] != wr[i]) begin
            bad++; $display("FAIL rand_lost[%0d]: got %0d results exp %0d", i, rd[i], wr[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_add_wrap;
      test_sub;
      test_cross_slice;
      test_back_to_back;
      test_flush;
      test_async_reset;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
